// File: rtl/trade_report_tx_pkg.sv
// Shared definitions for the trade report transmitter: ASCII symbols, FSM encodings,
// UART bit timing (shared with the command receiver) and the frame byte formatter.
package trade_report_tx_pkg;

    localparam int CLK_FREQ     = 50_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    localparam logic [7:0] ASCII_B     = 8'h42;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam logic [3:0] LAST_BYTE_IDX = 4'd8;

    typedef enum logic [1:0] {
        FMT_IDLE = 2'd0,
        FMT_LOAD = 2'd1,
        FMT_SEND = 2'd2,
        FMT_WAIT = 2'd3
    } fmt_state_t;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_t;

    typedef struct packed {
        logic        side;
        logic [19:0] price;
    } trade_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            bcd_to_ascii = ASCII_ZERO + {4'd0, digit};
        end else begin
            bcd_to_ascii = ASCII_QMARK;
        end
    endfunction

    // Byte idx of the "X:ddd.ff\n" frame for one trade event.
    function automatic logic [7:0] frame_byte(input trade_t ev, input logic [3:0] idx);
        case (idx)
            4'd0:    frame_byte = ev.side ? ASCII_B : ASCII_S;
            4'd1:    frame_byte = ASCII_COLON;
            4'd2:    frame_byte = bcd_to_ascii(ev.price[19:16]);
            4'd3:    frame_byte = bcd_to_ascii(ev.price[15:12]);
            4'd4:    frame_byte = bcd_to_ascii(ev.price[11:8]);
            4'd5:    frame_byte = ASCII_DOT;
            4'd6:    frame_byte = bcd_to_ascii(ev.price[7:4]);
            4'd7:    frame_byte = bcd_to_ascii(ev.price[3:0]);
            4'd8:    frame_byte = ASCII_LF;
            default: frame_byte = ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/trade_report_tx_uart_tx.sv
// 8N1 byte serialiser. A start request during the last clock of a stop bit chains
// straight into the next start bit so consecutive bytes leave no idle gap.
module trade_report_tx_uart_tx
    import trade_report_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = trade_report_tx_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    utx_state_t      r_state;
    utx_state_t      w_state_nxt;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_bit_end;
    logic            w_load;

    assign w_bit_end = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign o_done    = (r_state == UTX_STOP) && w_bit_end;
    assign w_load    = i_start && ((r_state == UTX_IDLE) || o_done);
    assign o_tx      = r_tx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= UTX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UTX_IDLE: begin
                if (i_start) w_state_nxt = UTX_START;
                else         w_state_nxt = UTX_IDLE;
            end
            UTX_START: begin
                if (w_bit_end) w_state_nxt = UTX_DATA;
                else           w_state_nxt = UTX_START;
            end
            UTX_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = UTX_STOP;
                else                              w_state_nxt = UTX_DATA;
            end
            UTX_STOP: begin
                if (w_bit_end) w_state_nxt = i_start ? UTX_START : UTX_IDLE;
                else           w_state_nxt = UTX_STOP;
            end
            default: w_state_nxt = UTX_IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and registered line driver.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else if (w_load) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= i_data;
            r_tx    <= 1'b0;
        end else if (r_state == UTX_IDLE) begin
            r_baud <= '0;
            r_tx   <= 1'b1;
        end else begin
            r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
            if (w_bit_end) begin
                case (r_state)
                    UTX_START: r_tx <= r_shift[0];
                    UTX_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                    default: r_tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/trade_report_tx.sv
// Trade report transmitter: two-slot event buffer, frame byte mux and formatter FSM
// feeding the byte serialiser with back-to-back bytes and frames.
module trade_report_tx
    import trade_report_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = trade_report_tx_pkg::CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trade_valid,
    output logic        trade_ready,
    input  logic        trade_side,
    input  logic [19:0] trade_price,
    output logic        tx,
    output logic        busy
);

    fmt_state_t  r_state;
    fmt_state_t  w_state_nxt;
    trade_t      r_act;
    trade_t      r_pend;
    logic        r_act_full;
    logic        r_pend_full;
    logic [3:0]  r_idx;
    logic        r_ready;
    logic        r_busy;

    trade_t      w_in;
    trade_t      w_sel;
    trade_t      w_act_nxt;
    trade_t      w_pend_nxt;
    logic        w_act_full_nxt;
    logic        w_pend_full_nxt;
    logic [3:0]  w_sel_idx;
    logic [3:0]  w_idx_nxt;
    logic [7:0]  w_byte;
    logic        w_start;
    logic        w_done;
    logic        w_accept;
    logic        w_last;
    logic        w_pop;

    assign w_in        = '{side: trade_side, price: trade_price};
    assign w_accept    = trade_valid && r_ready;
    assign w_last      = (r_idx == LAST_BYTE_IDX);
    assign w_pop       = (r_state == FMT_WAIT) && w_done && w_last;
    assign w_byte      = frame_byte(w_sel, w_sel_idx);
    assign trade_ready = r_ready;
    assign busy        = r_busy;

    trade_report_tx_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_data (w_byte),
        .o_tx   (tx),
        .o_done (w_done)
    );

    // Formatter state and byte index registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FMT_IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Formatter next state; WAIT issues the following byte (or the pending frame's
    // first byte) on the same clock the serialiser finishes, keeping the line busy.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sel       = r_act;
        w_sel_idx   = r_idx;
        w_start     = 1'b0;
        case (r_state)
            FMT_IDLE: begin
                w_idx_nxt = 4'd0;
                if (w_accept || r_act_full) w_state_nxt = FMT_LOAD;
                else                        w_state_nxt = FMT_IDLE;
            end
            FMT_LOAD: w_state_nxt = FMT_SEND;
            FMT_SEND: begin
                w_start     = 1'b1;
                w_state_nxt = FMT_WAIT;
            end
            FMT_WAIT: begin
                if (w_done && !w_last) begin
                    w_start   = 1'b1;
                    w_sel_idx = r_idx + 4'd1;
                    w_idx_nxt = r_idx + 4'd1;
                end else if (w_done && r_pend_full) begin
                    w_start   = 1'b1;
                    w_sel     = r_pend;
                    w_sel_idx = 4'd0;
                    w_idx_nxt = 4'd0;
                end else if (w_done) begin
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = w_accept ? FMT_LOAD : FMT_IDLE;
                end else begin
                    w_state_nxt = FMT_WAIT;
                end
            end
            default: w_state_nxt = FMT_IDLE;
        endcase
    end

    // Slot bookkeeping: frame end promotes pending, then a new event fills the first free slot.
    always_comb begin
        w_act_nxt       = r_act;
        w_act_full_nxt  = r_act_full;
        w_pend_nxt      = r_pend;
        w_pend_full_nxt = r_pend_full;
        if (w_pop && r_pend_full) begin
            w_act_nxt       = r_pend;
            w_pend_full_nxt = 1'b0;
        end else if (w_pop) begin
            w_act_full_nxt = 1'b0;
        end else begin
            w_act_full_nxt = r_act_full;
        end
        if (w_accept && !w_act_full_nxt) begin
            w_act_nxt      = w_in;
            w_act_full_nxt = 1'b1;
        end else if (w_accept) begin
            w_pend_nxt      = w_in;
            w_pend_full_nxt = 1'b1;
        end else begin
            w_pend_nxt = w_pend_nxt;
        end
    end

    // Slot registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_act       <= '0;
            r_pend      <= '0;
            r_act_full  <= 1'b0;
            r_pend_full <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_act       <= w_act_nxt;
            r_pend      <= w_pend_nxt;
            r_act_full  <= w_act_full_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_ready     <= !w_pend_full_nxt;
            r_busy      <= w_act_full_nxt || w_pend_full_nxt;
        end
    end

endmodule

// File: tb/tb_trade_report_tx.sv
// Scoreboard bench for trade_report_tx: accepted events push their expected ASCII bytes,
// a UART monitor decodes tx at mid-bit and compares each received byte.
module tb_trade_report_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 90 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trade_valid = 1'b0;
    logic        trade_side = 1'b0;
    logic [19:0] trade_price = 20'h00000;
    logic        trade_ready;
    logic        tx;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_rx = 0;
    bit          mon_abort = 1'b1;
    logic [7:0]  exp_q[$];
    int          start_cyc[$];

    trade_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .trade_valid(trade_valid),
        .trade_ready(trade_ready),
        .trade_side (trade_side),
        .trade_price(trade_price),
        .tx         (tx),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART monitor / scoreboard consumer
    initial begin : monitor
        logic [7:0] b;
        bit ok;
        int sc;
        b = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!mon_abort && tx === 1'b0) begin
                sc = cyc;
                ok = 1'b1;
                repeat (CPB / 2) @(posedge clk);
                #1;
                if (mon_abort) ok = 1'b0;
                else check("start_bit", tx, 32'd0);
                for (int i = 0; i < 8 && ok; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    if (mon_abort) ok = 1'b0;
                    else b[i] = tx;
                end
                if (ok) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    if (mon_abort) ok = 1'b0;
                    else check("stop_bit", tx, 32'd1);
                end
                if (ok) begin
                    start_cyc.push_back(sc);
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h expected none", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input bit side, input logic [19:0] price, input string exp_s, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        @(negedge clk);
        trade_valid = 1'b1;
        trade_side  = side;
        trade_price = price;
        for (int k = 0; k < 4 * FRAME && !done; k++) begin
            if (trade_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                done = 1'b1;
                for (int i = 0; i < exp_s.len(); i++) exp_q.push_back(exp_s[i]);
            end else begin
                @(negedge clk);
            end
        end
        trade_valid = 1'b0;
        trade_side  = ~side;
        trade_price = 20'hFFFFF;
        check("accept_timeout", done, 32'd1);
    endtask

    task automatic wait_rx(input int target, input string name);
        int k;
        k = 0;
        while (n_rx < target && k < 6 * FRAME) begin
            @(posedge clk);
            k++;
        end
        check(name, n_rx, target);
    endtask

    task automatic wait_idle(output int t);
        int k;
        k = 0;
        t = -1;
        while (k < 6 * FRAME && t < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (busy === 1'b0) t = cyc;
        end
        check("idle_timeout", (t >= 0), 32'd1);
    endtask

    task automatic check_gaps(input int first, input int n, input string name);
        int bad;
        bad = 0;
        for (int k = first + 1; k < first + n; k++) begin
            if (start_cyc[k] - start_cyc[k-1] != 10 * CPB) bad++;
        end
        check(name, bad, 32'd0);
    endtask

    task automatic check_quiet(input int cycles, input string name);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check(name, lows, 32'd0);
    endtask

    initial begin : main
        int a0, a1, a2, a3, base, t_idle;

        // reset
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_tx", tx, 32'd1);
        check("reset_busy", busy, 32'd0);
        check("reset_ready", trade_ready, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        mon_abort = 1'b0;
        check_quiet(3 * CPB, "idle_tx_quiet");
        check("idle_no_bytes", n_rx, 32'd0);

        // single buy
        send(1'b1, 20'h12345, "B:123.45\n", a0);
        check("t2_busy_after_accept", busy, 32'd1);
        wait_rx(9, "t2_frame_bytes");
        wait_idle(t_idle);
        check("t2_start_latency", start_cyc[0] - a0, 32'd2);
        check("t2_busy_drop", t_idle - start_cyc[0], FRAME);
        check_gaps(0, 9, "t2_byte_gaps");

        // back-to-back events plus a third held off by ready
        base = n_rx;
        send(1'b0, 20'h20000, "S:200.00\n", a1);
        send(1'b1, 20'h00099, "B:000.99\n", a2);
        check("t3_accept_spacing", a2 - a1, 32'd1);
        check("t3_ready_low", trade_ready, 32'd0);
        send(1'b1, 20'h98760, "B:987.60\n", a3);
        wait_rx(base + 27, "t3_frame_bytes");
        wait_idle(t_idle);
        check_gaps(base, 27, "t3_no_idle_gap");
        check("t6_accept_after_frame1", a3 - start_cyc[base + 9], 32'd1);
        check_quiet(3 * CPB, "t6_no_extra_frame");
        check("t6_sent_once", n_rx - base, 32'd27);

        // invalid BCD digit
        base = n_rx;
        send(1'b1, 20'h1A345, "B:1?3.45\n", a0);
        wait_rx(base + 9, "t4_frame_bytes");
        wait_idle(t_idle);

        // reset during byte 4
        base = n_rx;
        send(1'b0, 20'h45678, "S:456.78\n", a0);
        wait_rx(base + 4, "t5_first_bytes");
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_abort = 1'b1;
        @(posedge clk);
        #1;
        check("t5_tx_high", tx, 32'd1);
        check("t5_ready", trade_ready, 32'd1);
        check("t5_busy", busy, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("t5_leftover_expected", exp_q.size(), 32'd5);
        exp_q.delete();
        repeat (2 * CPB) @(posedge clk);
        mon_abort = 1'b0;
        check_quiet(3 * CPB, "t5_no_resume");
        check("t5_partial_bytes", n_rx - base, 32'd4);
        base = n_rx;
        send(1'b1, 20'h00001, "B:000.01\n", a0);
        wait_rx(base + 9, "t5_new_frame_bytes");
        wait_idle(t_idle);
        check("t5_start_latency", start_cyc[base] - a0, 32'd2);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
